// File: rtl/des_f_pipe_pkg.sv
// Shared DES round constants: widths, E/P bit tables, S-box contents.
// Bit numbers in the tables are DES-style, 1-based with bit 1 as the MSB.
package des_f_pipe_pkg;

  localparam int HALF_W   = 32;
  localparam int SUBKEY_W = 48;
  localparam int SBOX_N   = 8;

  localparam int E_TAB [SUBKEY_W] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [HALF_W] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  // One 256-bit word per box: 64 nibbles, entry (row*16+col) at nibble 0 = MSBs.
  localparam logic [255:0] SBOX [SBOX_N] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  typedef struct packed {
    logic [HALF_W-1:0]   l;
    logic [HALF_W-1:0]   r;
    logic [SUBKEY_W-1:0] x;
    logic                last;
  } s1_t;

  // Row is {a6,a1}, column a5..a2; together they form the table index.
  function automatic logic [5:0] sbox_idx(input logic [5:0] a);
    return {a[5], a[0], a[4:1]};
  endfunction

endpackage

// File: rtl/des_f_pipe_if.sv
// Input/output stream handshake for one DES round beat.
interface des_f_pipe_if;
  import des_f_pipe_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [HALF_W-1:0]   in_l;
  logic [HALF_W-1:0]   in_r;
  logic [SUBKEY_W-1:0] in_k;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [HALF_W-1:0]   out_l;
  logic [HALF_W-1:0]   out_r;
  logic [HALF_W-1:0]   out_f;

  modport slave (
    input  in_valid, in_l, in_r, in_k, in_last, out_ready,
    output in_ready, out_valid, out_l, out_r, out_f
  );

  modport master (
    output in_valid, in_l, in_r, in_k, in_last, out_ready,
    input  in_ready, out_valid, out_l, out_r, out_f
  );

endinterface

// File: rtl/des_f_pipe_sbox_bank.sv
// Combinational S-box layer: eight 6-to-4 lookups, S1 on the MSBs.
module des_sbox
  import des_f_pipe_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [5:0] i_a,
  output logic [3:0] o_s
);

  logic [5:0] w_sel;

  assign w_sel = 6'd63 - sbox_idx(i_a);
  assign o_s   = SBOX[IDX][{w_sel, 2'b00} +: 4];

endmodule

module des_sbox_bank
  import des_f_pipe_pkg::*;
(
  input  logic [SUBKEY_W-1:0] i_x,
  output logic [HALF_W-1:0]   o_s
);

  for (genvar gi = 0; gi < SBOX_N; gi++) begin : g_sbox
    des_sbox #(.IDX(gi)) u_sbox (
      .i_a (i_x[SUBKEY_W-1-6*gi -: 6]),
      .o_s (o_s[HALF_W-1-4*gi -: 4])
    );
  end

endmodule

// File: rtl/des_f_pipe.sv
// Two-stage DES round: stage 1 registers E(R)^K, stage 2 registers S/P and the
// Feistel mix. Each stage loads when empty or when its successor drains.
module des_f_pipe
  import des_f_pipe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  des_f_pipe_if.slave   bus
);

  localparam int STAGES = 2;

  logic [STAGES:1]     r_vld_pipe;
  s1_t                 r_s1;
  logic [HALF_W-1:0]   r_out_l;
  logic [HALF_W-1:0]   r_out_r;
  logic [HALF_W-1:0]   r_out_f;

  logic                w_s1_adv;
  logic                w_s2_adv;
  logic                w_acc;
  logic [SUBKEY_W-1:0] w_e;
  logic [HALF_W-1:0]   w_sbox;
  logic [HALF_W-1:0]   w_f;
  logic [HALF_W-1:0]   w_mix;

  for (genvar gi = 0; gi < SUBKEY_W; gi++) begin : g_e
    assign w_e[SUBKEY_W-1-gi] = bus.in_r[HALF_W-E_TAB[gi]];
  end

  des_sbox_bank u_sbox_bank (
    .i_x (r_s1.x),
    .o_s (w_sbox)
  );

  for (genvar gi = 0; gi < HALF_W; gi++) begin : g_p
    assign w_f[HALF_W-1-gi] = w_sbox[HALF_W-P_TAB[gi]];
  end

  // in_ready depends only on state and out_ready, never on in_valid.
  assign w_s2_adv = !r_vld_pipe[2] || bus.out_ready;
  assign w_s1_adv = !r_vld_pipe[1] || w_s2_adv;
  assign w_acc    = bus.in_valid && w_s1_adv;
  assign w_mix    = r_s1.l ^ w_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_out_l    <= '0;
      r_out_r    <= '0;
      r_out_f    <= '0;
    end else begin
      if (w_s1_adv) r_vld_pipe[1] <= w_acc;
      if (w_s2_adv) r_vld_pipe[2] <= r_vld_pipe[1];
      if (w_acc) begin
        r_s1.l    <= bus.in_l;
        r_s1.r    <= bus.in_r;
        r_s1.x    <= w_e ^ bus.in_k;
        r_s1.last <= bus.in_last;
      end
      // Final round leaves the halves unswapped.
      if (w_s2_adv && r_vld_pipe[1]) begin
        r_out_f <= w_f;
        r_out_l <= r_s1.last ? w_mix  : r_s1.r;
        r_out_r <= r_s1.last ? r_s1.r : w_mix;
      end
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_vld_pipe[2];
  assign bus.out_l     = r_out_l;
  assign bus.out_r     = r_out_r;
  assign bus.out_f     = r_out_f;

endmodule

// File: tb/tb_des_f_pipe.sv
// Bench for des_f_pipe: directed round vectors, stall/reset sequences and a
// random valid/ready stream scored against a table-driven f model.
module tb_des_f_pipe;
  import des_f_pipe_pkg::*;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [47:0] k;
    logic        last;
    logic [31:0] f;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  typedef struct packed {
    logic [31:0] f;
    logic [31:0] l;
    logic [31:0] r;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  des_f_pipe_if bus ();

  des_f_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_in   = 0;
  int   n_out  = 0;
  int   n_drop = 0;
  res_t q[$];
  vec_t tv[5];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic vld);
    bus.in_valid = vld;
    bus.in_l     = v.l;
    bus.in_r     = v.r;
    bus.in_k     = v.k;
    bus.in_last  = v.last;
  endtask

  function automatic res_t model(input logic [31:0] l, input logic [31:0] r,
                                 input logic [47:0] k, input logic last);
    logic [47:0] x;
    logic [31:0] s, p;
    logic [5:0]  a;
    int          idx;
    res_t        res;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TAB[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      a   = x[47-6*b -: 6];
      idx = (a[5] * 2 + a[0]) * 16 + int'(a[4:1]);
      s[31-4*b -: 4] = SBOX[b][255-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
    res.f = p;
    res.l = last ? (l ^ p) : r;
    res.r = last ? r : (l ^ p);
    return res;
  endfunction

  // Stream scoreboard and hold-stability monitor, sampled mid-cycle.
  logic hold_p = 1'b0;
  logic rst_p  = 1'b1;
  res_t out_p  = '0;
  always @(negedge clk) begin
    res_t cur, e;
    cur = {bus.out_f, bus.out_l, bus.out_r};
    if (hold_p && !rst_p) chk("hold_stable", cur, out_p);
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got beat %h expected none", cur);
      end else begin
        e = q.pop_front();
        chk("stream", cur, e);
      end
    end
    if (rst) begin
      n_drop += q.size();
      q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      q.push_back(model(bus.in_l, bus.in_r, bus.in_k, bus.in_last));
      n_in++;
    end
    hold_p = bus.out_valid && !bus.out_ready;
    rst_p  = rst;
    out_p  = cur;
  end

  initial begin
    int stale;
    int cyc;
    int start;

    tv[0] = '{32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0, 32'h234AA9BB, 32'hF0AAF0AA, 32'hEF4A6544};
    tv[1] = '{32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1, 32'h234AA9BB, 32'hEF4A6544, 32'hF0AAF0AA};
    tv[2] = '{32'h00000000, 32'h00000000, 48'h000000000000, 1'b0, 32'hD8D8DBBC, 32'h00000000, 32'hD8D8DBBC};
    tv[3] = '{32'hFFFFFFFF, 32'h00000000, 48'h000000000000, 1'b1, 32'hD8D8DBBC, 32'h27272443, 32'h00000000};
    tv[4] = '{32'h00000000, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0, 32'hD8D8DBBC, 32'hFFFFFFFF, 32'hD8D8DBBC};

    drive(tv[2], 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 96'(bus.out_valid), 96'd0);
    chk("rst_in_ready", 96'(bus.in_ready), 96'd1);
    chk("rst_outs", {bus.out_f, bus.out_l, bus.out_r}, 96'd0);

    // Single beats, latency and result per vector.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(tv[i], 1'b1);
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_lat1", i), 96'(bus.out_valid), 96'd0);
      step();
      chk($sformatf("v%0d_valid", i), 96'(bus.out_valid), 96'd1);
      chk($sformatf("v%0d_res", i), {bus.out_f, bus.out_l, bus.out_r}, {tv[i].f, tv[i].el, tv[i].er});
    end
    step();
    step();

    // Three beats into a stalled sink, then release.
    bus.out_ready = 1'b0;
    drive(tv[0], 1'b1);
    step();
    chk("stall_ready1", 96'(bus.in_ready), 96'd1);
    drive(tv[2], 1'b1);
    step();
    chk("stall_ready2", 96'(bus.in_ready), 96'd0);
    chk("stall_head", {bus.out_f, bus.out_l, bus.out_r}, {tv[0].f, tv[0].el, tv[0].er});
    drive(tv[4], 1'b1);
    step();
    chk("stall_ready3", 96'(bus.in_ready), 96'd0);
    step();
    chk("stall_hold", {bus.out_f, bus.out_l, bus.out_r}, {tv[0].f, tv[0].el, tv[0].er});
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("drain_b", {28'd0, bus.out_valid, bus.out_f, bus.out_l, bus.out_r}, {28'd1, tv[2].f, tv[2].el, tv[2].er});
    step();
    chk("drain_c", {28'd0, bus.out_valid, bus.out_f, bus.out_l, bus.out_r}, {28'd1, tv[4].f, tv[4].el, tv[4].er});
    step();
    chk("drain_empty", 96'(bus.out_valid), 96'd0);

    // Reset with both stages full and stalled.
    bus.out_ready = 1'b0;
    drive(tv[0], 1'b1);
    step();
    drive(tv[1], 1'b1);
    step();
    chk("full_ready", 96'(bus.in_ready), 96'd0);
    rst = 1'b1;
    drive(tv[3], 1'b1);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", 96'(bus.out_valid), 96'd0);
    chk("flush_ready", 96'(bus.in_ready), 96'd1);
    chk("flush_outs", {bus.out_f, bus.out_l, bus.out_r}, 96'd0);
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      step();
      if (bus.out_valid) stale++;
    end
    chk("flush_no_stale", 96'(stale), 96'd0);

    // A beat offered during reset on an empty pipe must be dropped.
    rst = 1'b1;
    drive(tv[0], 1'b1);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    stale = 0;
    repeat (4) begin
      step();
      if (bus.out_valid) stale++;
    end
    chk("rst_drop", 96'(stale), 96'd0);

    // Random traffic with random backpressure.
    start = n_in;
    cyc   = 0;
    while ((n_in - start) < 10000 && cyc < 60000) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_l      = $urandom;
      bus.in_r      = $urandom;
      bus.in_k      = {16'($urandom), $urandom};
      bus.in_last   = 1'($urandom % 2);
      bus.out_ready = ($urandom % 4) != 0;
      step();
      cyc++;
    end
    chk("rand_budget", 96'((n_in - start) >= 10000), 96'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("rand_queue_empty", 96'(q.size()), 96'd0);
    chk("in_eq_out", 96'(n_out), 96'(n_in - n_drop));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
